// File: rtl/axi_bfm_pkg.sv
// Shared constants for the AXI BFM response path:
// packet framing bytes, field positions and arbiter states.
package axi_bfm_pkg;

    localparam logic [7:0] SOP    = 8'hAA;
    localparam logic [7:0] EOP    = 8'h53;
    localparam logic [7:0] TYPE_B = 8'h01;
    localparam logic [7:0] TYPE_R = 8'h02;

    localparam int SOP_LSB  = 120;
    localparam int TYPE_LSB = 112;
    localparam int ID_LSB   = 108;
    localparam int RESP_LSB = 104;
    localparam int DATA_LSB = 72;
    localparam int LAST_LSB = 64;
    localparam int EOP_LSB  = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_B = 2'd1;
    localparam logic [1:0] ST_GNT_R = 2'd2;

    localparam logic SRC_B = 1'b0;
    localparam logic SRC_R = 1'b1;

endpackage

// File: rtl/axi_rsp_arbiter_if.sv
// B/R response channels plus the response FIFO write port,
// seen from the sources (master) and the arbiter (slave).
interface axi_rsp_arbiter_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
);
    logic              b_valid;
    logic              b_ready;
    logic [ID_W-1:0]   bid;
    logic [3:0]        bresp;
    logic              r_valid;
    logic              r_ready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [3:0]        rresp;
    logic              rlast;
    logic              fifo_afull;
    logic              write_enable;
    logic [127:0]      fifo_wdata;

    modport master (
        output b_valid, bid, bresp,
        output r_valid, rid, rdata, rresp, rlast,
        output fifo_afull,
        input  b_ready, r_ready, write_enable, fifo_wdata
    );

    modport slave (
        input  b_valid, bid, bresp,
        input  r_valid, rid, rdata, rresp, rlast,
        input  fifo_afull,
        output b_ready, r_ready, write_enable, fifo_wdata
    );
endinterface

// File: rtl/rsp_pkt_pack.sv
// Packs the granted source's fields into one
// SOP/EOP-framed 128-bit FIFO word.
module rsp_pkt_pack
    import axi_bfm_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic              sel_r,
    input  logic [ID_W-1:0]   bid,
    input  logic [3:0]        bresp,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [3:0]        rresp,
    input  logic              rlast,
    output logic [127:0]      word
);

    // Unused fields stay zero; narrow ID/data are zero-extended.
    always_comb begin
        word                 = '0;
        word[SOP_LSB +: 8]   = SOP;
        word[EOP_LSB +: 8]   = EOP;
        if (sel_r) begin
            word[TYPE_LSB +: 8]  = TYPE_R;
            word[ID_LSB +: 4]    = 4'(rid);
            word[RESP_LSB +: 4]  = rresp;
            word[DATA_LSB +: 32] = 32'(rdata);
            word[LAST_LSB]       = rlast;
        end else begin
            word[TYPE_LSB +: 8]  = TYPE_B;
            word[ID_LSB +: 4]    = 4'(bid);
            word[RESP_LSB +: 4]  = bresp;
        end
    end

endmodule

// File: rtl/axi_rsp_arbiter.sv
// Round-robin B/R arbiter feeding the response FIFO through
// a registered push stage; R bursts are never interleaved.
module axi_rsp_arbiter
    import axi_bfm_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_rsp_arbiter_if.slave bus,
    output logic [CNT_W-1:0] b_pkt_cnt,
    output logic [CNT_W-1:0] r_beat_cnt,
    output logic             r_busy
);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic         last_gnt;
    logic         b_acc;
    logic         r_acc;
    logic [127:0] pkt;

    function automatic logic [1:0] pick(
        input logic bv,
        input logic rv,
        input logic favour_r
    );
        if (bv && rv) return favour_r ? ST_GNT_R : ST_GNT_B;
        if (bv)       return ST_GNT_B;
        if (rv)       return ST_GNT_R;
        return ST_IDLE;
    endfunction

    assign bus.b_ready = (state == ST_GNT_B) & bus.b_valid
                       & ~bus.fifo_afull;
    assign bus.r_ready = (state == ST_GNT_R) & bus.r_valid
                       & ~bus.fifo_afull;
    assign b_acc = bus.b_valid & bus.b_ready;
    assign r_acc = bus.r_valid & bus.r_ready;

    // Next grant: fair from idle, favour the other source after a packet.
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == ST_GNT_B): begin
                if (b_acc)
                    state_nxt = pick(bus.b_valid, bus.r_valid, 1'b1);
                else if (!bus.b_valid)
                    state_nxt = ST_IDLE;
            end
            (state == ST_GNT_R): begin
                if (r_acc && bus.rlast)
                    state_nxt = pick(bus.b_valid, bus.r_valid, 1'b0);
                else if (!bus.r_valid && !r_busy)
                    state_nxt = ST_IDLE;
            end
            default:
                state_nxt = pick(bus.b_valid, bus.r_valid,
                                 last_gnt == SRC_B);
        endcase
    end

    // Grant state and the source that most recently won.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last_gnt <= SRC_R;
        end else begin
            state <= state_nxt;
            if (state_nxt == ST_GNT_B) last_gnt <= SRC_B;
            if (state_nxt == ST_GNT_R) last_gnt <= SRC_R;
        end
    end

    // Burst tracking: busy between first accepted beat and rlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_busy <= 1'b0;
        else if (r_acc) r_busy <= ~bus.rlast;
    end

    // Wrapping packet and beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_pkt_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (b_acc) b_pkt_cnt  <= b_pkt_cnt + 1'b1;
            if (r_acc) r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    rsp_pkt_pack #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W)
    ) u_pack (
        .sel_r (state == ST_GNT_R),
        .bid   (bus.bid),
        .bresp (bus.bresp),
        .rid   (bus.rid),
        .rdata (bus.rdata),
        .rresp (bus.rresp),
        .rlast (bus.rlast),
        .word  (pkt)
    );

    // Registered FIFO push; data holds when nothing is pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.write_enable <= 1'b0;
            bus.fifo_wdata   <= '0;
        end else begin
            bus.write_enable <= b_acc | r_acc;
            if (b_acc | r_acc) bus.fifo_wdata <= pkt;
        end
    end

endmodule
